// File: rtl/insn_fetch.sv
// Instruction fetch unit: prefetches sequential words from a handshaked memory
// into a small tagged FIFO and delivers a word only when its tag matches the core PC.
module insn_fetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] fetch_addr,
  input  logic          insn_take,
  output logic [31:0]   insn,
  output logic          insn_valid,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pf_addr;
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          fifo_empty;
  logic [AW-1:0] head_addr;
  logic [31:0]   head_data;
  logic [AW-1:0] exp_addr;
  logic          redirect;
  logic          pop;
  logic          push;
  logic [CW-1:0] count_next;
  logic          space;
  logic [AW-1:0] issue_addr;

  always_comb begin
    fifo_empty = (count == '0);
    head_addr  = fifo_addr[rd_ptr];
    head_data  = fifo_data[rd_ptr];
    insn_valid = !fifo_empty && (head_addr == fetch_addr);
    insn       = insn_valid ? head_data : '0;

    // In DISCARD the outstanding word is already abandoned; pf_addr holds the target.
    if (!fifo_empty)       exp_addr = head_addr;
    else if (state == REQ) exp_addr = mem_addr;
    else                   exp_addr = pf_addr;

    redirect   = (fetch_addr != exp_addr);
    pop        = insn_valid && insn_take && !redirect;
    push       = (state == REQ) && mem_ack && !redirect;
    count_next = redirect ? '0 : (count - CW'(pop) + CW'(push));
    space      = (count_next < CW'(DEPTH));
    issue_addr = redirect ? fetch_addr : pf_addr;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mem_addr;
      fifo_data[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pf_addr  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      count <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
      end

      case (state)
        IDLE: begin
          if (space) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= issue_addr;
            pf_addr  <= issue_addr + AW'(1);
          end
        end
        REQ, DISCARD: begin
          if (mem_ack) begin
            // A redirect always empties the FIFO, so the no-space branch never needs fetch_addr.
            if (space) begin
              state    <= REQ;
              mem_req  <= 1'b1;
              mem_addr <= issue_addr;
              pf_addr  <= issue_addr + AW'(1);
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end else if (redirect) begin
            state   <= DISCARD;
            pf_addr <= fetch_addr;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: memory word[a] = a + 0x100, expected values
// written out by hand for each step.
module tb_insn_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_addr;
  logic        insn_take;
  logic [31:0] insn;
  logic        insn_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr + 32'h100;

  insn_fetch #(.DEPTH(4), .AW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_addr (fetch_addr),
    .insn_take  (insn_take),
    .insn       (insn),
    .insn_valid (insn_valid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic reset_dut(input logic [31:0] pc, input logic take, input logic ack);
    rst_n      = 1'b0;
    fetch_addr = pc;
    insn_take  = take;
    mem_ack    = ack;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    fetch_addr = '0;
    insn_take  = 1'b0;
    mem_ack    = 1'b0;
    #1;
    chk("rst_req",   mem_req,    0);
    chk("rst_addr",  mem_addr,   0);
    chk("rst_valid", insn_valid, 0);
    chk("rst_insn",  insn,       0);

    // Sequential fetch, ack tied high
    reset_dut(0, 1'b1, 1'b1);
    tick(); #1;
    chk("seq_p1_valid", insn_valid, 0);
    chk("seq_p1_req",   mem_req,    1);
    chk("seq_p1_addr",  mem_addr,   0);
    tick(); #1;
    chk("seq_p2_valid", insn_valid, 1);
    chk("seq_p2_insn",  insn,       32'h100);
    chk("seq_p2_addr",  mem_addr,   1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      fetch_addr = i;
      #1;
      chk("seq_valid", insn_valid, 1);
      chk("seq_insn",  insn,       32'h100 + i);
      chk("seq_addr",  mem_addr,   i + 1);
    end

    // Reset while the request for address 7 is outstanding
    chk("rstm_pre_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstm_req",   mem_req,    0);
    chk("rstm_valid", insn_valid, 0);
    chk("rstm_insn",  insn,       0);
    chk("rstm_addr",  mem_addr,   0);
    fetch_addr = 32'h30;
    tick();
    chk("rstm_hold_req", mem_req, 0);
    rst_n = 1'b1;
    #1;
    tick(); #1;
    chk("rstm_restart_req",   mem_req,    1);
    chk("rstm_restart_addr",  mem_addr,   32'h30);
    chk("rstm_restart_valid", insn_valid, 0);
    tick(); #1;
    chk("rstm_first_valid", insn_valid, 1);
    chk("rstm_first_insn",  insn,       32'h130);

    // Fill until full with take low
    reset_dut(0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk("fill_req",  mem_req,  1);
      chk("fill_addr", mem_addr, k);
    end
    tick(); #1;
    chk("full_req",   mem_req,    0);
    chk("full_valid", insn_valid, 1);
    chk("full_insn",  insn,       32'h100);
    tick(); #1;
    chk("full_req_hold", mem_req, 0);
    insn_take = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      fetch_addr = k;
      #1;
      chk("drain_valid", insn_valid, 1);
      chk("drain_insn",  insn,       32'h100 + k);
      chk("drain_req",   mem_req,    1);
      chk("drain_addr",  mem_addr,   k + 3);
    end

    // Redirect from PC 3 to 20 with the FIFO non-empty
    tick();
    fetch_addr = 20;
    #1;
    chk("redir_valid0", insn_valid, 0);
    chk("redir_addr0",  mem_addr,   7);
    tick(); #1;
    chk("redir_valid1", insn_valid, 0);
    chk("redir_req1",   mem_req,    1);
    chk("redir_addr1",  mem_addr,   20);
    tick(); #1;
    chk("redir_valid2", insn_valid, 1);
    chk("redir_insn2",  insn,       32'h114);
    chk("redir_addr2",  mem_addr,   21);
    tick();
    fetch_addr = 21;
    #1;
    chk("redir_insn3", insn, 32'h115);

    // Redirect to 40 while the request for address 5 is outstanding
    reset_dut(0, 1'b1, 1'b1);
    tick();
    tick(); #1;
    chk("out_first_insn", insn, 32'h100);
    for (int i = 1; i <= 4; i++) begin
      tick();
      fetch_addr = i;
      #1;
      chk("out_seq_insn", insn,     32'h100 + i);
      chk("out_seq_addr", mem_addr, i + 1);
    end
    mem_ack = 1'b0;
    tick();
    fetch_addr = 40;
    #1;
    chk("out_wait_valid", insn_valid, 0);
    chk("out_wait_addr",  mem_addr,   5);
    tick(); #1;
    chk("out_disc_req",   mem_req,    1);
    chk("out_disc_addr",  mem_addr,   5);
    chk("out_disc_valid", insn_valid, 0);
    mem_ack = 1'b1;
    tick(); #1;
    chk("out_new_addr",  mem_addr,   40);
    chk("out_new_valid", insn_valid, 0);
    tick(); #1;
    chk("out_tgt_valid", insn_valid, 1);
    chk("out_tgt_insn",  insn,       32'h128);

    // Ack arrives two cycles after each request
    reset_dut(0, 1'b1, 1'b0);
    tick(); #1;
    chk("lat_p1_req",  mem_req,  1);
    chk("lat_p1_addr", mem_addr, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      fetch_addr = k;
      #1;
      chk("lat_wait_req",   mem_req,    1);
      chk("lat_wait_addr",  mem_addr,   k);
      chk("lat_wait_valid", insn_valid, 0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("lat_got_valid", insn_valid, 1);
      chk("lat_got_insn",  insn,       32'h100 + k);
      chk("lat_got_addr",  mem_addr,   k + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
